// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction and a flush sweep.
// Optional gshare counter indexing when the BTB_GSHARE_EN macro is defined.
module btb_predictor #(
   parameter int unsigned ENTRIES = 128,
   parameter int unsigned PC_W    = 32,
   parameter int unsigned CTR_W   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [PC_W-1:0] f_PC,
   input  logic [PC_W-1:0] e_PC,
   input  logic [PC_W-1:0] target_address,
   input  logic            taken,
   input  logic            is_branch,
   input  logic            flush,
   output logic [PC_W-1:0] pred_address,
   output logic            pred_take,
   output logic            found,
   output logic            busy
);
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] CTR_MAX    = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK_T = {1'b1, {(CTR_W-1){1'b0}}};
   localparam logic [CTR_W-1:0] CTR_WEAK_N = {1'b0, {(CTR_W-1){1'b1}}};

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     sweep_q, sweep_d;
   logic                 upd_en, clr_en;

   logic [ENTRIES-1:0]   valid_q;
   logic [PC_W-1:0]      tag_q [ENTRIES];
   logic [PC_W-1:0]      tgt_q [ENTRIES];
   logic [CTR_W-1:0]     ctr_q [ENTRIES];

   logic [IDX_W-1:0]     f_idx, e_idx, f_cidx, e_cidx;
   logic                 e_hit, tgt_we;
   logic [CTR_W-1:0]     ctr_old, ctr_inc, ctr_dec, ctr_new;
   logic                 l_valid, l_found, l_take;
   logic [PC_W-1:0]      l_tag, l_tgt;
   logic [CTR_W-1:0]     l_ctr;

   assign f_idx = f_PC[IDX_W+1:2];
   assign e_idx = e_PC[IDX_W+1:2];

`ifdef BTB_GSHARE_EN
   logic [IDX_W-1:0] hist_q;

   // Global direction history, shifted on every accepted update
   always_ff @(posedge clk) begin
      if (!rst_n)      hist_q <= '0;
      else if (upd_en) hist_q <= {hist_q[IDX_W-2:0], taken};
   end

   assign f_cidx = f_idx ^ hist_q;
   assign e_cidx = e_idx ^ hist_q;
`else
   assign f_cidx = f_idx;
   assign e_cidx = e_idx;
`endif

   // Flush sweep FSM; updates are only accepted in IDLE without a flush request
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      upd_en  = 1'b0;
      clr_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               state_d = S_FLUSH;
               sweep_d = '0;
            end else begin
               upd_en = is_branch;
            end
         end
         S_FLUSH: begin
            clr_en  = 1'b1;
            sweep_d = sweep_q + IDX_W'(1);
            if (sweep_q == IDX_W'(ENTRIES-1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // New entry contents for the resolved branch
   always_comb begin
      e_hit   = valid_q[e_idx] && (tag_q[e_idx] == e_PC);
      ctr_old = ctr_q[e_cidx];
      ctr_inc = (ctr_old == CTR_MAX) ? ctr_old : ctr_old + CTR_W'(1);
      ctr_dec = (ctr_old == '0)      ? ctr_old : ctr_old - CTR_W'(1);
      tgt_we  = taken || !e_hit;
`ifdef BTB_GSHARE_EN
      ctr_new = taken ? ctr_inc : ctr_dec;
`else
      if (e_hit) ctr_new = taken ? ctr_inc : ctr_dec;
      else       ctr_new = taken ? CTR_WEAK_T : CTR_WEAK_N;
`endif
   end

   // Lookup with write-first bypass of a same-cycle update
   always_comb begin
      l_valid = valid_q[f_idx];
      l_tag   = tag_q[f_idx];
      l_tgt   = tgt_q[f_idx];
      l_ctr   = ctr_q[f_cidx];
      if (upd_en && (e_idx == f_idx)) begin
         l_valid = 1'b1;
         l_tag   = e_PC;
         if (tgt_we) l_tgt = target_address;
      end
      if (upd_en && (e_cidx == f_cidx)) l_ctr = ctr_new;
      l_found = (state_q == S_IDLE) && l_valid && (l_tag == f_PC);
      l_take  = l_found && l_ctr[CTR_W-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sweep_q      <= '0;
         valid_q      <= '0;
         found        <= 1'b0;
         pred_take    <= 1'b0;
         pred_address <= '0;
         busy         <= 1'b0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         busy      <= (state_d == S_FLUSH);
         if (clr_en) valid_q[sweep_q] <= 1'b0;
         if (upd_en) valid_q[e_idx]   <= 1'b1;
         found     <= l_found;
         pred_take <= l_take;
         if (l_take) pred_address <= l_tgt;
      end
   end

   // Payload arrays carry no reset; they are qualified by valid_q
   always_ff @(posedge clk) begin
      if (rst_n && upd_en) begin
         tag_q[e_idx]  <= e_PC;
         ctr_q[e_cidx] <= ctr_new;
         if (tgt_we) tgt_q[e_idx] <= target_address;
      end
   end
endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: lookups push expectations, a monitor compares registered results.
// Define BTB_GSHARE_EN to run the history-indexed convergence test instead of the directed set.
module tb_btb_predictor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] f_PC, e_PC, target_address;
   logic        taken, is_branch, flush;
   logic [31:0] pred_address;
   logic        pred_take, found, busy;

   typedef struct packed {
      logic        found;
      logic        take;
      logic        chk_addr;
      logic [31:0] addr;
      logic [7:0]  id;
   } exp_t;

   exp_t exp_q[$];
   logic lk_req = 1'b0;
   logic lk_d   = 1'b0;
   int   total  = 0;
   int   bad    = 0;
   int   cnt;

   btb_predictor #(.ENTRIES(128), .PC_W(32), .CTR_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .f_PC(f_PC), .e_PC(e_PC),
      .target_address(target_address), .taken(taken), .is_branch(is_branch),
      .flush(flush), .pred_address(pred_address), .pred_take(pred_take),
      .found(found), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      is_branch = 1'b0;
      flush     = 1'b0;
      lk_req    = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic f, input logic t,
                         input logic ca, input logic [31:0] a, input logic [7:0] id);
      exp_t e;
      f_PC   = pc;
      lk_req = 1'b1;
      e.found = f; e.take = t; e.chk_addr = ca; e.addr = a; e.id = id;
      exp_q.push_back(e);
   endtask

   task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
      e_PC           = pc;
      taken          = t;
      target_address = tgt;
      is_branch      = 1'b1;
   endtask

   // Monitor: results of a lookup sampled at edge N are visible after edge N
   always @(posedge clk) lk_d <= lk_req;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (lk_d) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_lookup: got=1 expected=0");
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("found[%0d]", e.id), 32'(found), 32'(e.found));
               chk($sformatf("pred_take[%0d]", e.id), 32'(pred_take), 32'(e.take));
               if (e.chk_addr) chk($sformatf("pred_address[%0d]", e.id), pred_address, e.addr);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; f_PC = '0; e_PC = '0; target_address = '0;
      taken = 1'b0; is_branch = 1'b0; flush = 1'b0;
      repeat (3) tick();
      chk("rst_pred_address", pred_address, 32'h0);
      chk("rst_pred_take", 32'(pred_take), 32'h0);
      chk("rst_found", 32'(found), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      tick();

`ifdef BTB_GSHARE_EN
      // Alternating T,N at one PC; history separates the two counters
      for (int k = 1; k <= 16; k++) begin
         if (k >= 13) begin
            lookup(32'h100, 1'b1, 1'(k % 2), 1'b1, 32'h400, 8'(k));
            tick();
         end
         update(32'h100, 1'(k % 2), 32'h400);
         tick();
      end
`else
      lookup(32'h100, 1'b0, 1'b0, 1'b1, 32'h0, 8'd1);
      tick();
      // Cold miss allocates weakly taken
      update(32'h100, 1'b1, 32'h400);
      tick();
      lookup(32'h100, 1'b1, 1'b1, 1'b1, 32'h400, 8'd2);
      tick();
      update(32'h100, 1'b0, 32'h400);
      tick();
      lookup(32'h100, 1'b1, 1'b0, 1'b1, 32'h400, 8'd3);
      tick();
      repeat (3) begin
         update(32'h100, 1'b0, 32'h400);
         tick();
      end
      lookup(32'h100, 1'b1, 1'b0, 1'b1, 32'h400, 8'd4);
      tick();
      // Fifth decrement must not wrap: one taken then still predicts not-taken
      update(32'h100, 1'b0, 32'h400);
      tick();
      lookup(32'h100, 1'b1, 1'b0, 1'b1, 32'h400, 8'd5);
      tick();
      update(32'h100, 1'b1, 32'h500);
      tick();
      lookup(32'h100, 1'b1, 1'b0, 1'b1, 32'h400, 8'd6);
      tick();
      update(32'h100, 1'b1, 32'h500);
      tick();
      lookup(32'h100, 1'b1, 1'b1, 1'b1, 32'h500, 8'd7);
      tick();
      // Aliasing at index 0x40
      lookup(32'h300, 1'b0, 1'b0, 1'b1, 32'h500, 8'd8);
      tick();
      update(32'h300, 1'b0, 32'h600);
      tick();
      lookup(32'h100, 1'b0, 1'b0, 1'b1, 32'h500, 8'd9);
      tick();
      lookup(32'h300, 1'b1, 1'b0, 1'b1, 32'h500, 8'd10);
      tick();
      // Same-cycle update and lookup
      update(32'h200, 1'b1, 32'h800);
      lookup(32'h200, 1'b1, 1'b1, 1'b1, 32'h800, 8'd11);
      tick();
      // Flush sweep with a late update that must be dropped
      flush = 1'b1;
      tick();
      cnt = 0;
      while (busy && cnt < 200) begin
         if (cnt == 120) begin
            update(32'h100, 1'b1, 32'h900);
            lookup(32'h200, 1'b0, 1'b0, 1'b1, 32'h800, 8'd12);
         end
         tick();
         cnt++;
      end
      chk("busy_cycles", 32'(cnt), 32'd128);
      lookup(32'h100, 1'b0, 1'b0, 1'b1, 32'h800, 8'd13);
      tick();
      lookup(32'h200, 1'b0, 1'b0, 1'b1, 32'h800, 8'd14);
      tick();
      lookup(32'h300, 1'b0, 1'b0, 1'b1, 32'h800, 8'd15);
      tick();
      // Reset in the middle of a sweep
      update(32'h1FC, 1'b1, 32'hB00);
      tick();
      lookup(32'h1FC, 1'b1, 1'b1, 1'b1, 32'hB00, 8'd16);
      tick();
      flush = 1'b1;
      tick();
      repeat (10) tick();
      chk("busy_mid_sweep", 32'(busy), 32'h1);
      rst_n = 1'b0;
      tick();
      chk("busy_after_rst", 32'(busy), 32'h0);
      chk("addr_after_rst", pred_address, 32'h0);
      rst_n = 1'b1;
      lookup(32'h1FC, 1'b0, 1'b0, 1'b1, 32'h0, 8'd17);
      tick();
      update(32'h100, 1'b1, 32'hA00);
      tick();
      lookup(32'h100, 1'b1, 1'b1, 1'b1, 32'hA00, 8'd18);
      tick();
`endif
      repeat (3) tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
